// File: rtl/ew_pad_mux_pkg.sv
`default_nettype none
// ============================================================================
// ew_pad_mux_pkg
// Shared types and helpers for the N-design pad-sharing controller.
// Revision: 1.0
// ============================================================================
package ew_pad_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    // One extra bit so that the value N (the "none" index) is representable.
    function automatic int unsigned sel_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

    localparam int unsigned MAX_DESIGNS = 8;
    localparam int unsigned MAX_SEL_W   = $clog2(MAX_DESIGNS) + 1;

endpackage
`default_nettype wire

// File: rtl/ew_reset_lock.sv
`default_nettype none
// ============================================================================
// ew_reset_lock
// Per-design LA reset-lock: synchronised lock pair, hold counter, reset out.
// Revision: 1.0
// ============================================================================
module ew_reset_lock #(
    parameter int SYNC_STAGES = 2,
    parameter int RESET_HOLD  = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_lock_a,
    input  logic i_lock_b,
    input  logic i_la_invalid,
    input  logic i_qualify,
    output logic o_reset
);

    localparam int c_CW = $clog2(RESET_HOLD + 1);

    logic [SYNC_STAGES-1:0] r_a_sync;
    logic [SYNC_STAGES-1:0] r_b_sync;
    logic [c_CW-1:0]        r_cnt;
    logic                   w_unlocked;

    assign w_unlocked = (r_a_sync[SYNC_STAGES-1] != r_b_sync[SYNC_STAGES-1])
                        && !i_la_invalid && i_qualify;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_a_sync <= '0;
            r_b_sync <= '0;
            r_cnt    <= '0;
        end else begin
            r_a_sync <= {r_a_sync[SYNC_STAGES-2:0], i_lock_a};
            r_b_sync <= {r_b_sync[SYNC_STAGES-2:0], i_lock_b};
            if (!w_unlocked) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CW'(RESET_HOLD)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_reset = (r_cnt != c_CW'(RESET_HOLD));

endmodule
`default_nettype wire

// File: rtl/ew_pad_mux.sv
`default_nettype none
// ============================================================================
// ew_pad_mux
// Shares one pad group among N designs with guarded switchover and reset-lock.
// Revision: 1.0
// ============================================================================
module ew_pad_mux
    import ew_pad_mux_pkg::*;
#(
    parameter int N_DESIGNS       = 4,
    parameter int N_PADS          = 9,
    parameter int SYNC_STAGES     = 2,
    parameter int RESET_HOLD      = 8,
    parameter int GUARD_CYCLES    = 4,
    parameter int HOLD_UNSELECTED = 1,
    localparam int SW             = sel_width(N_DESIGNS)
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_la_invalid,
    input  logic [N_DESIGNS-1:0]          i_lock_a,
    input  logic [N_DESIGNS-1:0]          i_lock_b,
    input  logic [SW-1:0]                 i_sel,
    input  logic [N_DESIGNS*N_PADS-1:0]   i_d_out,
    input  logic [N_DESIGNS*N_PADS-1:0]   i_d_oeb,
    output logic [N_PADS-1:0]             o_io_out,
    output logic [N_PADS-1:0]             o_io_oeb,
    output logic [N_DESIGNS-1:0]          o_d_reset,
    output logic [SW-1:0]                 o_active,
    output logic                          o_busy
);

    localparam int          c_GW         = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [SW-1:0]   c_NONE       = SW'(N_DESIGNS);
    localparam logic [c_GW-1:0] c_GUARD_LOAD = c_GW'(GUARD_CYCLES - 1);

    logic [SYNC_STAGES-1:0][SW-1:0] r_sel_sync;
    logic [SYNC_STAGES-1:0]         r_inv_sync;
    state_t                         r_state;
    logic [SW-1:0]                  r_active;
    logic [SW-1:0]                  r_target;
    logic [c_GW-1:0]                r_guard;

    logic [SW-1:0]                  w_sel_s;
    logic                           w_sel_valid;
    logic                           w_inv_s;
    logic [N_DESIGNS-1:0]           w_qual;

    assign w_sel_s     = r_sel_sync[SYNC_STAGES-1];
    assign w_inv_s     = r_inv_sync[SYNC_STAGES-1];
    assign w_sel_valid = (w_sel_s < c_NONE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sel_sync <= '0;
            r_inv_sync <= '0;
            r_state    <= ST_IDLE;
            r_active   <= c_NONE;
            r_target   <= c_NONE;
            r_guard    <= '0;
        end else begin
            r_sel_sync <= {r_sel_sync[SYNC_STAGES-2:0], i_sel};
            r_inv_sync <= {r_inv_sync[SYNC_STAGES-2:0], i_la_invalid};
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        r_target <= w_sel_s;
                        r_guard  <= c_GUARD_LOAD;
                        r_state  <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    // A changed request restarts the full guard rather than shortening it.
                    if (w_sel_s != r_target) begin
                        if (w_sel_valid) begin
                            r_target <= w_sel_s;
                            r_guard  <= c_GUARD_LOAD;
                        end else begin
                            r_active <= c_NONE;
                            r_state  <= ST_IDLE;
                        end
                    end else if (r_guard == '0) begin
                        r_active <= r_target;
                        r_state  <= ST_DRIVE;
                    end else begin
                        r_guard <= r_guard - 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (!w_sel_valid) begin
                        r_active <= c_NONE;
                        r_state  <= ST_IDLE;
                    end else if (w_sel_s != r_active) begin
                        r_target <= w_sel_s;
                        r_guard  <= c_GUARD_LOAD;
                        r_state  <= ST_GUARD;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_io_out = '0;
        o_io_oeb = '1;
        if (r_state == ST_DRIVE) begin
            for (int k = 0; k < N_DESIGNS; k++) begin
                if (r_active == SW'(k)) begin
                    o_io_out = i_d_out[k*N_PADS +: N_PADS];
                    o_io_oeb = i_d_oeb[k*N_PADS +: N_PADS];
                end
            end
        end
    end

    assign o_active = r_active;
    assign o_busy   = (r_state == ST_GUARD);

    generate
        for (genvar k = 0; k < N_DESIGNS; k++) begin : g_lock
            assign w_qual[k] = (HOLD_UNSELECTED == 0) ||
                               ((r_state == ST_DRIVE) && (r_active == SW'(k)));
            ew_reset_lock #(
                .SYNC_STAGES (SYNC_STAGES),
                .RESET_HOLD  (RESET_HOLD)
            ) u_lock (
                .i_clk        (i_clk),
                .i_reset      (i_reset),
                .i_lock_a     (i_lock_a[k]),
                .i_lock_b     (i_lock_b[k]),
                .i_la_invalid (w_inv_s),
                .i_qualify    (w_qual[k]),
                .o_reset      (o_d_reset[k])
            );
        end
    endgenerate

endmodule
`default_nettype wire
